// File: rtl/mssd_frame_scheduler.sv
// Round-robin scheduler sharing one MSSD serial input between four requesters.
// Serializes start bit, 2-bit port address, 4-bit length and L LSB-first data bits, paced by clk_en.
module mssd_frame_scheduler #(
  parameter int DW       = 16,
  parameter int GAP_BITS = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clk_en,
  input  logic [3:0]      req,
  input  logic [15:0]     len_i,
  input  logic [4*DW-1:0] data_i,
  output logic [3:0]      gnt,
  output logic            ser_out,
  output logic            busy,
  output logic [1:0]      cur_src,
  output logic            frame_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_ADDR, S_LEN, S_DATA, S_GAP
  } state_t;

  state_t          r_state, w_next;
  logic [1:0]      r_ptr, w_ptr_nx;
  logic [1:0]      r_src, w_src_nx;
  logic [3:0]      r_cnt, w_cnt_nx;
  logic            r_done, w_done_nx;
  logic [3:0]      r_len;
  logic [DW-1:0]   r_shift;
  logic [2:0]      w_pick;
  logic            w_grant;
  logic [3:0]      w_len_sel;
  logic [DW-1:0]   w_data_sel;

  // Returns {hit, index} of the first request at or after ptr, wrapping 3->0.
  function automatic logic [2:0] rr_pick(input logic [3:0] rq, input logic [1:0] ptr);
    logic [1:0] idx;
    rr_pick = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      idx = ptr + 2'(i);
      if (rq[idx]) rr_pick = {1'b1, idx};
    end
  endfunction

  assign w_pick     = rr_pick(req, r_ptr);
  assign busy       = (r_state != S_IDLE);
  assign cur_src    = r_src;
  assign frame_done = r_done;

  always_comb begin
    w_len_sel  = len_i[3:0];
    w_data_sel = data_i[DW-1:0];
    case (w_pick[1:0])
      2'd1: begin w_len_sel = len_i[7:4];   w_data_sel = data_i[2*DW-1:DW];   end
      2'd2: begin w_len_sel = len_i[11:8];  w_data_sel = data_i[3*DW-1:2*DW]; end
      2'd3: begin w_len_sel = len_i[15:12]; w_data_sel = data_i[4*DW-1:3*DW]; end
      default: ;
    endcase
  end

  always_comb begin
    w_next    = r_state;
    w_cnt_nx  = r_cnt;
    w_ptr_nx  = r_ptr;
    w_src_nx  = r_src;
    w_done_nx = 1'b0;
    w_grant   = 1'b0;
    gnt       = 4'b0000;
    ser_out   = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (w_pick[2] && !rst) begin
          w_grant           = 1'b1;
          gnt[w_pick[1:0]]  = 1'b1;
          w_src_nx          = w_pick[1:0];
          w_ptr_nx          = w_pick[1:0] + 2'd1;
          w_next            = S_START;
        end
      end
      S_START: begin
        ser_out = 1'b0;
        if (clk_en) begin
          w_next   = S_ADDR;
          w_cnt_nx = 4'd0;
        end
      end
      S_ADDR: begin
        ser_out = r_src[~r_cnt[0]];
        if (clk_en) begin
          if (r_cnt == 4'd1) begin
            w_next   = S_LEN;
            w_cnt_nx = 4'd0;
          end else begin
            w_cnt_nx = r_cnt + 4'd1;
          end
        end
      end
      S_LEN: begin
        ser_out = r_len[2'd3 - r_cnt[1:0]];
        if (clk_en) begin
          if (r_cnt == 4'd3) begin
            w_cnt_nx = 4'd0;
            if (r_len == 4'd0) begin
              w_next    = S_GAP;
              w_done_nx = 1'b1;
            end else begin
              w_next = S_DATA;
            end
          end else begin
            w_cnt_nx = r_cnt + 4'd1;
          end
        end
      end
      S_DATA: begin
        ser_out = r_shift[0];
        if (clk_en) begin
          if (r_cnt == r_len - 4'd1) begin
            w_next    = S_GAP;
            w_cnt_nx  = 4'd0;
            w_done_nx = 1'b1;
          end else begin
            w_cnt_nx = r_cnt + 4'd1;
          end
        end
      end
      S_GAP: begin
        if (clk_en) begin
          if (r_cnt == 4'(GAP_BITS - 1)) begin
            w_next   = S_IDLE;
            w_cnt_nx = 4'd0;
          end else begin
            w_cnt_nx = r_cnt + 4'd1;
          end
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Control registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_ptr   <= 2'd0;
      r_src   <= 2'd0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nx;
      r_ptr   <= w_ptr_nx;
      r_src   <= w_src_nx;
      r_done  <= w_done_nx;
    end
  end

  // Frame payload captured at grant; data shifts out LSB first
  always_ff @(posedge clk) begin
    if (w_grant) begin
      r_len   <= w_len_sel;
      r_shift <= w_data_sel;
    end else if (r_state == S_DATA && clk_en) begin
      r_shift <= {1'b0, r_shift[DW-1:1]};
    end
  end

endmodule

// File: tb/tb_mssd_frame_scheduler.sv
// Bench for mssd_frame_scheduler: directed and randomized frames checked against a
// queue-of-bits frame model and a round-robin pointer model.
module tb_mssd_frame_scheduler;
  localparam int GAP_BITS = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        clk_en;
  logic [3:0]  req;
  logic [15:0] len_i;
  logic [63:0] data_i;
  logic [3:0]  gnt;
  logic        ser_out;
  logic        busy;
  logic [1:0]  cur_src;
  logic        frame_done;

  logic [3:0]  req_nx;
  logic [15:0] len_nx;
  logic [63:0] data_nx;
  int n_tests = 0;
  int n_fail  = 0;
  int en_period = 0;
  int cyc_n = 0;
  int tb_ptr = 0;
  int kk;

  always #5 clk = ~clk;

  mssd_frame_scheduler #(.DW(16), .GAP_BITS(GAP_BITS)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .req(req), .len_i(len_i), .data_i(data_i),
    .gnt(gnt), .ser_out(ser_out), .busy(busy), .cur_src(cur_src), .frame_done(frame_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
  task automatic next_cycle();
    @(posedge clk);
    #1;
    cyc_n++;
    if (en_period == 0) clk_en = ($urandom_range(0, 2) == 0);
    else                clk_en = ((cyc_n % en_period) == 0);
    req    = req_nx;
    len_i  = len_nx;
    data_i = data_nx;
    #1;
  endtask

  function automatic int pick(input logic [3:0] m);
    for (int i = 0; i < 4; i++)
      if (m[(tb_ptr + i) % 4]) return (tb_ptr + i) % 4;
    return -1;
  endfunction

  task automatic serve(input int k, input bit hold, input int chg_at, input int abort_at);
    bit q[$];
    logic [3:0]  L;
    logic [15:0] D;
    logic [3:0]  eg;
    int guard, used, gap;
    guard = 0;
    while (gnt == 4'b0000 && guard < 64) begin
      next_cycle();
      guard++;
    end
    eg = 4'b0001 << k;
    chk("gnt", gnt, eg);
    if (gnt !== eg) return;
    L = len_i[4*k +: 4];
    D = data_i[16*k +: 16];
    q.push_back(1'b0);
    q.push_back(k[1]);
    q.push_back(k[0]);
    for (int i = 3; i >= 0; i--) q.push_back(L[i]);
    for (int i = 0; i < int'(L); i++) q.push_back(D[i]);
    tb_ptr = (k + 1) % 4;
    if (!hold) req_nx[k] = 1'b0;
    used = 0;
    guard = 0;
    while (q.size() > 0 && guard < 4000) begin
      next_cycle();
      guard++;
      chk("busy", busy, 1);
      chk("cur_src", cur_src, k);
      chk("done_early", frame_done, 0);
      chk("gnt_busy", gnt, 0);
      if (clk_en) begin
        chk($sformatf("src%0d_bit%0d", k, used), ser_out, q.pop_front());
        used++;
        if (used == chg_at) begin
          data_nx[16*k +: 16] = ~D;
          req_nx[k] = 1'b0;
        end
        if (used == abort_at) return;
      end
    end
    chk("bits_timeout", q.size(), 0);
    gap = 0;
    guard = 0;
    while (gap < GAP_BITS && guard < 4000) begin
      next_cycle();
      guard++;
      if (guard == 1) chk("frame_done", frame_done, 1);
      else            chk("done_once", frame_done, 0);
      chk("gap_busy", busy, 1);
      if (clk_en) begin
        chk("gap_bit", ser_out, 1);
        gap++;
      end
    end
    chk("gap_timeout", gap, GAP_BITS);
    next_cycle();
    chk("idle_busy", busy, 0);
    chk("idle_ser", ser_out, 1);
    chk("idle_done", frame_done, 0);
  endtask

  initial begin
    rst = 1'b1; clk_en = 1'b0;
    req = '0; len_i = '0; data_i = '0;
    req_nx = '0; len_nx = '0; data_nx = '0;
    #2;
    chk("rst_ser", ser_out, 1);
    chk("rst_gnt", gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cur", cur_src, 0);
    chk("rst_done", frame_done, 0);
    req_nx = 4'b1111;
    next_cycle();
    chk("rst_gnt_req", gnt, 0);
    chk("rst_ser_req", ser_out, 1);
    req_nx = 4'b0000;
    next_cycle();
    rst = 1'b0;

    // Directed frame from source 2, clk_en every 4th cycle
    en_period = 4;
    req_nx = 4'b0100; len_nx[11:8] = 4'd3; data_nx[47:32] = 16'h0005;
    next_cycle();
    serve(2, 1'b0, 0, 0);

    // Source 3 random frame brings the pointer back to 0
    en_period = 0;
    len_nx = 16'($urandom); data_nx = {$urandom, $urandom}; req_nx = 4'b1000;
    next_cycle();
    serve(3, 1'b0, 0, 0);

    // All sources held with L=1
    len_nx = 16'h1111; data_nx = {$urandom, $urandom}; req_nx = 4'b1111;
    next_cycle();
    serve(0, 1'b1, 0, 0);
    serve(1, 1'b1, 0, 0);
    serve(2, 1'b1, 0, 0);
    serve(3, 1'b1, 0, 0);
    req_nx = 4'b0000;
    serve(0, 1'b0, 0, 0);

    // Zero-length frame from source 1
    en_period = 3;
    len_nx[7:4] = 4'd0; data_nx[31:16] = 16'hFFFF; req_nx = 4'b0010;
    next_cycle();
    serve(1, 1'b0, 0, 0);

    // Payload and request change mid-frame
    en_period = 0;
    len_nx[3:0] = 4'd12; data_nx[15:0] = 16'($urandom); req_nx = 4'b0001;
    next_cycle();
    serve(0, 1'b1, 9, 0);

    // Random request mixes
    for (int f = 0; f < 10; f++) begin
      if (req_nx == 4'b0000) begin
        req_nx  = 4'($urandom_range(1, 15));
        len_nx  = 16'($urandom);
        data_nx = {$urandom, $urandom};
        next_cycle();
      end
      kk = pick(req_nx);
      serve(kk, 1'b0, 0, 0);
      req_nx[kk] = 1'b0;
    end
    for (int f = 0; f < 4; f++) begin
      if (req_nx != 4'b0000) begin
        kk = pick(req_nx);
        serve(kk, 1'b0, 0, 0);
        req_nx[kk] = 1'b0;
      end
    end

    // Reset during DATA of an L=15 frame
    en_period = 2;
    len_nx[11:8] = 4'd15; data_nx[47:32] = 16'($urandom); req_nx = 4'b0100;
    next_cycle();
    serve(2, 1'b0, 0, 10);
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_ser", ser_out, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_gnt", gnt, 0);
    chk("mid_rst_cur", cur_src, 0);
    chk("mid_rst_done", frame_done, 0);
    tb_ptr = 0;
    #1 rst = 1'b0;
    req_nx = 4'b1100; len_nx = 16'($urandom); data_nx = {$urandom, $urandom};
    next_cycle();
    kk = pick(4'b1100);
    serve(kk, 1'b0, 0, 0);
    req_nx[kk] = 1'b0;
    if (req_nx != 4'b0000) begin
      kk = pick(req_nx);
      serve(kk, 1'b0, 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mssd_frame_scheduler.md
Name: mssd_frame_scheduler

Overview:
- Shares one MSSD serial input line between 4 local requesters.
- Each requester offers a payload, a length and its target port; the block arbitrates round-robin and serializes one complete MSSD frame at a time onto ser_out, which drives the MSSD SerIn.
- Bit pacing comes from clk_en, the same one-pulser tick the MSSD samples on, so each emitted bit is consumed exactly once.

Parameters:
- DW, 16, payload register width per requester (max data bits per frame; length field is 4 bits, so DW must be 16).
- GAP_BITS, 2, idle-high bit times inserted after every frame before the next start bit (1..7).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- clk_en  input  1  bit tick, one clk wide; a bit is consumed in every cycle where clk_en=1
- req  input  4  req[i] level request from source i; held until gnt[i]
- len_i  input  16  4 bits per source; source i at [4i+3:4i]; number of data bits, 0..15
- data_i  input  64  16 bits per source; source i at [16i+15:16i]
- gnt  output  4  one-hot, one-clk pulse; len/data of that source captured in the same cycle
- ser_out  output  1  serial frame line to MSSD SerIn; idle = 1
- busy  output  1  high from the cycle after grant through the last GAP bit
- cur_src  output  2  index of the source owning the current frame
- frame_done  output  1  one-clk pulse after the last frame bit is consumed

Behaviour:
- Reset (async, immediate, also mid-frame):
  - ser_out=1; gnt=0, busy=0, frame_done=0, cur_src=0.
  - RR pointer=0, state=IDLE.
  - A frame cut by reset is abandoned, not resumed.
- Frame format, bits in order:
  - start bit 0.
  - port address = source index, 2 bits, MSB first.
  - length L, 4 bits, MSB first.
  - L data bits from data_i, bit 0 first (LSB first).
  - Total 7+L bits.
- FSM states: IDLE, START, ADDR, LEN, DATA, GAP.
- IDLE:
  - Arbitrate every clk cycle, independent of clk_en.
  - Search req starting at the RR pointer, wrapping 3->0.
  - On a hit at source k: gnt[k]=1 for that cycle; capture len_i[k], data_i[k] and k.
  - Set pointer=(k+1) mod 4 and go to START.
  - Grant-to-ser_out latency is 1 clk; ser_out=0 from the next cycle.
- START/ADDR/LEN/DATA/GAP: the value on ser_out during a clk_en=1 cycle is the consumed bit. Advance to the next bit in the following cycle.
  - A clk_en coinciding with the grant cycle does not consume the start bit.
- Bit counters:
  - ADDR: 2 bits.
  - LEN: 4 bits.
  - DATA: L bits via a shift register.
  - GAP: GAP_BITS ticks with ser_out=1.
- L=0: go from LEN directly to GAP; no DATA bits.
- frame_done pulses in the cycle after the clk_en that consumes the last frame bit (last DATA bit, or last LEN bit if L=0); GAP is entered in the same cycle.
- After the last GAP tick, return to IDLE; busy drops in that same cycle. Arbitration resumes in that cycle.
- req/len_i/data_i changes after grant: no effect on the frame in flight.
- A req dropped before grant is simply not served.
- cur_src holds the last granted index until the next grant.
- Holding clk_en=0 freezes all state except IDLE arbitration. There is no timeout.

Test Plan:
- Reset while idle -> ser_out=1, gnt=0, busy=0, cur_src=0.
- req=4'b0100, len_i[11:8]=3, data_i[47:32]=16'h0005, clk_en every 4th cycle -> gnt=4'b0100 for 1 clk. Consumed bits 0,1,0,0,0,1,1,1,0,1. frame_done 1 clk after the 10th consumed bit, then 2 ticks of ser_out=1, then busy=0.
- req=4'b1111 held, all len=1 -> grant order 0,1,2,3,0. Address fields 00,01,10,11,00. Each frame is 8 bits followed by 2 gap ticks.
- Source 1 with L=0 -> 7 bits 0,0,1,0,0,0,0. frame_done after the 7th bit; no data bits emitted.
- Assert rst during the DATA bits of an L=15 frame -> ser_out=1 immediately (async), busy=0. The next grant after rst goes to the lowest requesting index (pointer=0).
- Change data_i[15:0] and drop req[0] mid-frame -> the emitted payload equals the value captured at grant, and the frame completes normally.
